// File: rtl/connect_n_pkg.sv
// Shared encodings for the Connect-N engine: game status, FSM states and
// the scan directions with their row/column step per direction.
package connect_n_pkg;

    localparam logic [1:0] ST_PLAY   = 2'b00;
    localparam logic [1:0] ST_P1_WIN = 2'b01;
    localparam logic [1:0] ST_P2_WIN = 2'b10;
    localparam logic [1:0] ST_DRAW   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

    // Horizontal, vertical, diagonal up-right, diagonal up-left.
    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_UR, DIR_UL} dir_t;

    localparam int DIR_DR [4] = '{0, 1, 1,  1};
    localparam int DIR_DC [4] = '{1, 0, 1, -1};

endpackage

// File: rtl/connect_n_line_counter.sv
// Combinational run-length counter: same-owner cells through the origin along
// one direction, each side capped at WIN_LEN-1, result capped at WIN_LEN.
module connect_n_line_counter
    import connect_n_pkg::*;
#(
    parameter int COLS    = 4,
    parameter int ROWS    = 4,
    parameter int WIN_LEN = 4,
    parameter int COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic [ROWS*COLS-1:0]         i_occupied,
    input  logic [ROWS*COLS-1:0]         i_owner,
    input  logic [$clog2(ROWS+1)-1:0]    i_row,
    input  logic [COL_W-1:0]             i_col,
    input  dir_t                         i_dir,
    input  logic                         i_mover,
    output logic [$clog2(WIN_LEN+1)-1:0] o_count
);

    localparam int CELLS = ROWS * COLS;
    localparam int CW    = $clog2(WIN_LEN + 1);

    function automatic int run_len(input logic [CELLS-1:0] occ,
                                   input logic [CELLS-1:0] own,
                                   input int row, input int col,
                                   input int dr, input int dc,
                                   input logic mover);
        int  n;
        int  r;
        int  c;
        logic alive;
        n     = 0;
        alive = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            r = row + k * dr;
            c = col + k * dc;
            if (alive && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                occ[r*COLS+c] && (own[r*COLS+c] == mover))
                n = n + 1;
            else
                alive = 1'b0;
        end
        return n;
    endfunction

    int w_dr;
    int w_dc;
    int w_total;

    assign w_dr = DIR_DR[i_dir];
    assign w_dc = DIR_DC[i_dir];

    always_comb begin
        w_total = 1
                + run_len(i_occupied, i_owner, int'(i_row), int'(i_col),  w_dr,  w_dc, i_mover)
                + run_len(i_occupied, i_owner, int'(i_row), int'(i_col), -w_dr, -w_dc, i_mover);
        o_count = (w_total >= WIN_LEN) ? CW'(WIN_LEN) : CW'(w_total);
    end

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N engine: edge-detected drops place a piece at the lowest free cell,
// then four CHECK cycles (one direction each) resolve win/draw/turn.
module connect_n_engine
    import connect_n_pkg::*;
#(
    parameter int COLS    = 4,
    parameter int ROWS    = 4,
    parameter int WIN_LEN = 4,
    parameter int COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 drop,
    input  logic [COL_W-1:0]     col_sel,
    output logic                 busy,
    output logic                 move_accepted,
    output logic                 move_rejected,
    output logic                 player,
    output logic [ROWS*COLS-1:0] occupied,
    output logic [ROWS*COLS-1:0] owner,
    output logic [1:0]           game_status
);

    localparam int CELLS = ROWS * COLS;
    localparam int HW    = $clog2(ROWS + 1);
    localparam int MW    = $clog2(CELLS + 1);
    localparam int CW    = $clog2(WIN_LEN + 1);

    state_t                  r_state;
    state_t                  w_state_nx;
    dir_t                    r_dir;
    logic                    r_drop_q;
    logic [COLS-1:0][HW-1:0] r_height;
    logic [MW-1:0]           r_moves;
    logic [HW-1:0]           r_prow;
    logic [COL_W-1:0]        r_pcol;
    logic                    r_win;
    logic                    r_player;
    logic [CELLS-1:0]        r_occ;
    logic [CELLS-1:0]        r_own;
    logic [1:0]              r_status;
    logic                    r_acc;
    logic                    r_rej;

    logic                    w_req;
    logic                    w_col_ok;
    logic [HW-1:0]           w_height;
    logic                    w_full;
    int                      w_idx;
    logic [CELLS-1:0]        w_mask;
    logic [CW-1:0]           w_count;
    logic                    w_win_any;
    logic                    w_board_full;
    logic                    w_accept;
    logic                    w_reject;
    logic                    w_resolve;

    assign w_req        = drop & ~r_drop_q;
    assign w_col_ok     = int'(col_sel) < COLS;
    assign w_height     = w_col_ok ? r_height[col_sel] : '0;
    assign w_full       = (w_height == HW'(ROWS));
    assign w_idx        = int'(w_height) * COLS + int'(col_sel);
    assign w_mask       = CELLS'(1) << w_idx;
    assign w_win_any    = r_win | (w_count >= CW'(WIN_LEN));
    assign w_board_full = (r_moves == MW'(CELLS));

    connect_n_line_counter #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .WIN_LEN (WIN_LEN),
        .COL_W   (COL_W)
    ) u_line (
        .i_occupied (r_occ),
        .i_owner    (r_own),
        .i_row      (r_prow),
        .i_col      (r_pcol),
        .i_dir      (r_dir),
        .i_mover    (r_player),
        .o_count    (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        w_resolve  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!w_col_ok || w_full) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept   = 1'b1;
                        w_state_nx = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (r_dir == DIR_UL) begin
                    w_resolve  = 1'b1;
                    w_state_nx = (w_win_any || w_board_full) ? S_DONE : S_IDLE;
                end
            end
            S_DONE:  w_reject = w_req;
            default: w_state_nx = S_IDLE;
        endcase
        // A fresh game aborts everything, including a same-cycle request.
        if (new_game) begin
            w_state_nx = S_IDLE;
            w_accept   = 1'b0;
            w_reject   = 1'b0;
            w_resolve  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_q <= 1'b0;
            r_height <= '0;
            r_moves  <= '0;
            r_prow   <= '0;
            r_pcol   <= '0;
            r_dir    <= DIR_H;
            r_win    <= 1'b0;
            r_player <= 1'b0;
            r_occ    <= '0;
            r_own    <= '0;
            r_status <= ST_PLAY;
            r_acc    <= 1'b0;
            r_rej    <= 1'b0;
        end else if (new_game) begin
            r_drop_q <= 1'b0;
            r_height <= '0;
            r_moves  <= '0;
            r_prow   <= '0;
            r_pcol   <= '0;
            r_dir    <= DIR_H;
            r_win    <= 1'b0;
            r_player <= 1'b0;
            r_occ    <= '0;
            r_own    <= '0;
            r_status <= ST_PLAY;
            r_acc    <= 1'b0;
            r_rej    <= 1'b0;
        end else begin
            r_drop_q <= drop;
            r_acc    <= w_accept;
            r_rej    <= w_reject;
            if (w_accept) begin
                r_occ             <= r_occ | w_mask;
                r_own             <= r_player ? (r_own | w_mask) : r_own;
                r_height[col_sel] <= w_height + HW'(1);
                r_moves           <= r_moves + MW'(1);
                r_prow            <= w_height;
                r_pcol            <= col_sel;
                r_dir             <= DIR_H;
                r_win             <= 1'b0;
            end
            if (r_state == S_CHECK) begin
                r_win <= w_win_any;
                r_dir <= dir_t'(r_dir + 2'd1);
            end
            if (w_resolve) begin
                if (w_win_any)         r_status <= r_player ? ST_P2_WIN : ST_P1_WIN;
                else if (w_board_full) r_status <= ST_DRAW;
                else                   r_player <= ~r_player;
            end
        end
    end

    assign busy          = (r_state == S_CHECK);
    assign move_accepted = r_acc;
    assign move_rejected = r_rej;
    assign player        = r_player;
    assign occupied      = r_occ;
    assign owner         = r_own;
    assign game_status   = r_status;

endmodule
